// File: rtl/vga_pkg.sv
// Shared defaults and types for the VGA scanout slice: timing defaults,
// dither mode encoding, the delay-line tap record and the Bayer index helper.
package vga_pkg;

    localparam int DEF_H_DISPLAY = 1220;
    localparam int DEF_H_FRONT   = 31;
    localparam int DEF_H_SYNC    = 183;
    localparam int DEF_H_BACK    = 92;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    typedef enum logic [1:0] {
        DM_ROUND        = 2'd0,
        DM_STATIC       = 2'd1,
        DM_TEMPORAL     = 2'd2,
        DM_TEMPORAL_ALT = 2'd3
    } dither_mode_e;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [2:0] h3;
        logic [1:0] v2;
        logic       f;
    } tap_t;

    // 5-bit ordered-dither rank of an 8x4 tile position; f flips the column
    // index so alternate frames use the complementary pattern.
    function automatic logic [4:0] bayer5(input logic [2:0] h3, input logic [1:0] v2,
                                          input logic f);
        logic [2:0] bi;
        logic [2:0] bx;
        bi = h3 ^ {3{f}};
        bx = {bi[2], bi[1] ^ v2[1], bi[0] ^ v2[0]};
        return {bx[0], bi[0], bx[1], bi[1], bx[2]};
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Scanout bus: control and colour from the pixel source, timing and pins back.
interface vga_scanout_if #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
);
    import vga_pkg::*;

    logic [1:0]          dither_mode;
    logic                frame_clear;
    logic [IN_BITS-1:0]  r_in;
    logic [IN_BITS-1:0]  g_in;
    logic [IN_BITS-1:0]  b_in;
    logic [10:0]         h_count;
    logic [9:0]          v_count;
    logic [10:0]         frame;
    logic                display_active;
    logic                line_start;
    logic                frame_start;
    logic                pre_line;
    logic                hsync;
    logic                vsync;
    logic [OUT_BITS-1:0] r_out;
    logic [OUT_BITS-1:0] g_out;
    logic [OUT_BITS-1:0] b_out;

    modport master (
        input  dither_mode, frame_clear, r_in, g_in, b_in,
        output h_count, v_count, frame, display_active, line_start, frame_start,
               pre_line, hsync, vsync, r_out, g_out, b_out
    );

    modport slave (
        output dither_mode, frame_clear, r_in, g_in, b_in,
        input  h_count, v_count, frame, display_active, line_start, frame_start,
               pre_line, hsync, vsync, r_out, g_out, b_out
    );

endinterface

// File: rtl/vga_scanout_bayer_dither.sv
// One colour channel: scale to DAC width with a supplied threshold, blank
// outside the visible area, and register the result.
module bayer_dither
    import vga_pkg::*;
#(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
) (
    input  logic                clk48,
    input  logic                rst_n,
    input  logic [IN_BITS-1:0]  c,
    input  logic [IN_BITS-1:0]  thr,
    input  logic                de,
    output logic [OUT_BITS-1:0] q
);

    localparam int SW = IN_BITS + OUT_BITS + 1;
    localparam logic [SW-1:0] LEVELS = SW'((1 << OUT_BITS) - 1);

    // One spare top bit keeps the sum exact; the quotient never exceeds LEVELS.
    logic [SW-1:0]       sum_s;
    logic [OUT_BITS-1:0] q_r;
    logic                unused_s;

    assign sum_s    = (SW'(c) * LEVELS) + SW'(thr);
    assign unused_s = ^{sum_s[IN_BITS-1:0], sum_s[SW-1]};

    // Output register, forced dark during blanking.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
        end else if (de) begin
            q_r <= sum_s[IN_BITS +: OUT_BITS];
        end else begin
            q_r <= '0;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/vga_scanout.sv
// VGA timing generator with delay-matched sync and per-channel ordered dither
// down to a narrow DAC; all pins leave PIPE+1 clocks after the counters.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int IN_BITS   = 6,
    parameter int OUT_BITS  = 2,
    parameter int PIPE      = 1,
    parameter int PRE_LINE  = 16,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0
) (
    input  logic          clk48,
    input  logic          rst_n,
    vga_scanout_if.master bus
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_DISP = 11'(H_DISPLAY);
    localparam logic [10:0] H_PRE  = 11'(H_DISPLAY - PRE_LINE);
    localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_DISP = 10'(V_DISPLAY);
    localparam logic [9:0]  VS_BEG = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]  VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    localparam logic HS_IDLE = (HSYNC_POL == 0) ? 1'b1 : 1'b0;
    localparam logic VS_IDLE = (VSYNC_POL == 0) ? 1'b1 : 1'b0;
    localparam logic [IN_BITS-1:0] HALF = {1'b1, {(IN_BITS-1){1'b0}}};

    logic [10:0]  h_r, h_nxt_s;
    logic [9:0]   v_r, v_nxt_s;
    logic [10:0]  frame_r;
    logic         wrap_s;
    logic         started_r;
    logic         pend_r;
    dither_mode_e mode_r;
    logic         de_r, ls_r, fs_r, pl_r;
    logic         hs_r, vs_r;

    // Next counter position; the first clock after reset holds at 0,0 so the
    // opening frame_start is visible.
    always_comb begin
        h_nxt_s = h_r;
        v_nxt_s = v_r;
        wrap_s  = 1'b0;
        if (!started_r) begin
            h_nxt_s = 11'd0;
            v_nxt_s = 10'd0;
        end else if (h_r == H_LAST) begin
            h_nxt_s = 11'd0;
            if (v_r == V_LAST) begin
                v_nxt_s = 10'd0;
                wrap_s  = 1'b1;
            end else begin
                v_nxt_s = v_r + 10'd1;
            end
        end else begin
            h_nxt_s = h_r + 11'd1;
        end
    end

    // Counters, frame bookkeeping and strobes, all registered from next state.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            started_r <= 1'b0;
            h_r       <= 11'd0;
            v_r       <= 10'd0;
            frame_r   <= 11'd0;
            pend_r    <= 1'b0;
            mode_r    <= DM_ROUND;
            de_r      <= 1'b0;
            ls_r      <= 1'b0;
            fs_r      <= 1'b0;
            pl_r      <= 1'b0;
        end else begin
            started_r <= 1'b1;
            h_r       <= h_nxt_s;
            v_r       <= v_nxt_s;
            de_r      <= (h_nxt_s < H_DISP) && (v_nxt_s < V_DISP);
            ls_r      <= (h_nxt_s == 11'd0);
            fs_r      <= (h_nxt_s == 11'd0) && (v_nxt_s == 10'd0);
            pl_r      <= (h_nxt_s == H_PRE);
            if (wrap_s) begin
                frame_r <= (pend_r || bus.frame_clear) ? 11'd0 : frame_r + 11'd1;
                pend_r  <= 1'b0;
                mode_r  <= dither_mode_e'(bus.dither_mode);
            end else begin
                pend_r  <= pend_r | bus.frame_clear;
            end
        end
    end

    tap_t cur_s;
    tap_t del_s;

    assign cur_s.hs = (h_r >= HS_BEG) && (h_r < HS_END);
    assign cur_s.vs = (v_r >= VS_BEG) && (v_r < VS_END);
    assign cur_s.de = de_r;
    assign cur_s.h3 = h_r[2:0];
    assign cur_s.v2 = v_r[1:0];
    assign cur_s.f  = frame_r[0];

    generate
        if (PIPE == 0) begin : g_nopipe
            assign del_s = cur_s;
        end else begin : g_pipe
            tap_t dly_r [PIPE];

            // Align timing with the colour arriving PIPE clocks late.
            always_ff @(posedge clk48 or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE; i++) begin
                        dly_r[i] <= '0;
                    end
                end else begin
                    dly_r[0] <= cur_s;
                    for (int i = 1; i < PIPE; i++) begin
                        dly_r[i] <= dly_r[i-1];
                    end
                end
            end

            assign del_s = dly_r[PIPE-1];
        end
    endgenerate

    logic               temporal_s;
    logic [4:0]         b5_s;
    logic [IN_BITS-1:0] thr_s;

    assign temporal_s = (mode_r == DM_TEMPORAL) || (mode_r == DM_TEMPORAL_ALT);
    assign b5_s       = bayer5(del_s.h3, del_s.v2, del_s.f & temporal_s);

    // Rounding threshold shared by all three channels.
    always_comb begin
        thr_s = HALF;
        case (mode_r)
            DM_ROUND:                               thr_s = HALF;
            DM_STATIC, DM_TEMPORAL, DM_TEMPORAL_ALT: thr_s = IN_BITS'(b5_s) << (IN_BITS - 5);
            default:                                thr_s = HALF;
        endcase
    end

    // Sync pins, registered in step with the colour channels.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            hs_r <= HS_IDLE;
            vs_r <= VS_IDLE;
        end else begin
            hs_r <= del_s.hs ^ HS_IDLE;
            vs_r <= del_s.vs ^ VS_IDLE;
        end
    end

    bayer_dither #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_dither_r (
        .clk48(clk48), .rst_n(rst_n), .c(bus.r_in), .thr(thr_s), .de(del_s.de), .q(bus.r_out)
    );
    bayer_dither #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_dither_g (
        .clk48(clk48), .rst_n(rst_n), .c(bus.g_in), .thr(thr_s), .de(del_s.de), .q(bus.g_out)
    );
    bayer_dither #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_dither_b (
        .clk48(clk48), .rst_n(rst_n), .c(bus.b_in), .thr(thr_s), .de(del_s.de), .q(bus.b_out)
    );

    assign bus.h_count        = h_r;
    assign bus.v_count        = v_r;
    assign bus.frame          = frame_r;
    assign bus.display_active = de_r;
    assign bus.line_start     = ls_r;
    assign bus.frame_start    = fs_r;
    assign bus.pre_line       = pl_r;
    assign bus.hsync          = hs_r;
    assign bus.vsync          = vs_r;

endmodule

// File: tb/tb_vga_scanout.sv
// Randomised bench for vga_scanout on a shrunken raster, checked every clock
// against a cycle-indexed reference built from the timing and dither rules.
module tb_vga_scanout;
    import vga_pkg::*;

    localparam int HD = 40, HF = 4, HS = 6, HB = 6;
    localparam int VD = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int PIPE = 3, PRE = 8, IB = 6, OB = 2;

    logic clk48 = 1'b0;
    logic rst_n = 1'b0;

    vga_scanout_if #(.IN_BITS(IB), .OUT_BITS(OB)) bus ();

    vga_scanout #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .IN_BITS(IB), .OUT_BITS(OB), .PIPE(PIPE), .PRE_LINE(PRE),
        .HSYNC_POL(0), .VSYNC_POL(0)
    ) dut (
        .clk48(clk48),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk48 = ~clk48;

    int n_checks = 0;
    int n_errors = 0;

    int n = 0;
    int m_h, m_v, m_frame, m_mode, m_started, m_pend;
    logic [1:0] dm_drv = 2'd0;
    logic       fc_drv = 1'b0;
    int col_mode = 0;
    int fix_r = 0;
    int st_valid [16];
    int st_h [16];
    int st_v [16];
    int st_f [16];
    int md_h [16];
    int rr [16];
    int rg [16];
    int rb [16];
    int px00_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference dither: ordered-dither rank of position, scaled level.
    function automatic int exp_colour(input int c, input int h, input int v, input int f,
                                      input int mode);
        int thr, bi, bj, bx0, bx1, bx2, b5;
        if (mode == 0) begin
            thr = 32;
        end else begin
            bi  = (h % 8) ^ (((mode >= 2) && (f % 2 == 1)) ? 7 : 0);
            bj  = v % 4;
            bx2 = (bi / 4) % 2;
            bx1 = ((bi / 2) % 2) ^ ((bj / 2) % 2);
            bx0 = (bi % 2) ^ (bj % 2);
            b5  = bx0 * 16 + (bi % 2) * 8 + bx1 * 4 + ((bi / 2) % 2) * 2 + bx2;
            thr = b5 * 2;
        end
        return (c * 3 + thr) / 64;
    endfunction

    function automatic int pick_colour();
        int k;
        k = int'($urandom_range(0, 3));
        if (k == 0) return 0;
        if (k == 1) return 32;
        if (k == 2) return 63;
        return int'($urandom_range(0, 63));
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_frame = 0; m_mode = 0; m_started = 0; m_pend = 0;
        for (int i = 0; i < 16; i++) begin
            st_valid[i] = 0; st_h[i] = 0; st_v[i] = 0; st_f[i] = 0; md_h[i] = 0;
            rr[i] = 0; rg[i] = 0; rb[i] = 0;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_h"}, 32'(bus.h_count), 32'd0);
        chk({tag, "_v"}, 32'(bus.v_count), 32'd0);
        chk({tag, "_frame"}, 32'(bus.frame), 32'd0);
        chk({tag, "_de"}, 32'(bus.display_active), 32'd0);
        chk({tag, "_strobes"}, 32'({bus.line_start, bus.frame_start, bus.pre_line}), 32'd0);
        chk({tag, "_sync"}, 32'({bus.hsync, bus.vsync}), 32'd3);
        chk({tag, "_rgb"}, 32'({bus.r_out, bus.g_out, bus.b_out}), 32'd0);
    endtask

    task automatic check_cycle();
        int c, s, r, eh, ev, ede, ehs, evs, er, eg, eb;
        bit sv;
        c  = n & 15;
        s  = (n - 1 - PIPE) & 15;
        r  = (n - 1) & 15;
        sv = (n - 1 - PIPE >= 0) && (st_valid[s] != 0);
        eh = st_h[c];
        ev = st_v[c];
        chk("h_count", 32'(bus.h_count), 32'(eh));
        chk("v_count", 32'(bus.v_count), 32'(ev));
        chk("frame", 32'(bus.frame), 32'(st_f[c]));
        chk("display_active", 32'(bus.display_active),
            32'((st_valid[c] != 0) && eh < HD && ev < VD));
        chk("line_start", 32'(bus.line_start), 32'((st_valid[c] != 0) && eh == 0));
        chk("frame_start", 32'(bus.frame_start), 32'((st_valid[c] != 0) && eh == 0 && ev == 0));
        chk("pre_line", 32'(bus.pre_line), 32'((st_valid[c] != 0) && eh == HD - PRE));
        ehs = 1; evs = 1; er = 0; eg = 0; eb = 0;
        if (sv) begin
            ehs = (st_h[s] >= HD + HF && st_h[s] < HD + HF + HS) ? 0 : 1;
            evs = (st_v[s] >= VD + VF && st_v[s] < VD + VF + VS) ? 0 : 1;
            ede = (st_h[s] < HD && st_v[s] < VD) ? 1 : 0;
            if (ede == 1) begin
                er = exp_colour(rr[r], st_h[s], st_v[s], st_f[s], md_h[r]);
                eg = exp_colour(rg[r], st_h[s], st_v[s], st_f[s], md_h[r]);
                eb = exp_colour(rb[r], st_h[s], st_v[s], st_f[s], md_h[r]);
            end
            if (st_h[s] == 0 && st_v[s] == 0) px00_q.push_back(int'(bus.r_out));
        end
        chk("hsync", 32'(bus.hsync), 32'(ehs));
        chk("vsync", 32'(bus.vsync), 32'(evs));
        chk("r_out", 32'(bus.r_out), 32'(er));
        chk("g_out", 32'(bus.g_out), 32'(eg));
        chk("b_out", 32'(bus.b_out), 32'(eb));
    endtask

    // One clock: drive this cycle's inputs at the negedge, advance the model at
    // the posedge, then check everything at the following negedge.
    task automatic cyc();
        int c, cr;
        c  = n & 15;
        cr = (col_mode == 1) ? fix_r : (col_mode == 2) ? pick_colour() : int'($urandom_range(0, 63));
        rr[c] = cr;
        rg[c] = int'($urandom_range(0, 63));
        rb[c] = int'($urandom_range(0, 63));
        bus.r_in        = IB'(rr[c]);
        bus.g_in        = IB'(rg[c]);
        bus.b_in        = IB'(rb[c]);
        bus.dither_mode = dm_drv;
        bus.frame_clear = fc_drv;
        @(posedge clk48);
        n++;
        if (rst_n) begin
            if (m_started == 0) begin
                m_started = 1; m_h = 0; m_v = 0;
                if (fc_drv) m_pend = 1;
            end else begin
                m_h++;
                if (m_h == HT) begin
                    m_h = 0;
                    m_v++;
                end
                if (m_v == VT) begin
                    m_v = 0;
                    m_frame = (m_pend != 0 || fc_drv) ? 0 : (m_frame + 1) % 2048;
                    m_pend = 0;
                    m_mode = int'(dm_drv);
                end else if (fc_drv) begin
                    m_pend = 1;
                end
            end
        end
        c = n & 15;
        st_valid[c] = m_started;
        st_h[c] = m_h;
        st_v[c] = m_v;
        st_f[c] = m_frame;
        md_h[c] = m_mode;
        @(negedge clk48);
        check_cycle();
    endtask

    task automatic run_to(input int th, input int tv);
        for (int i = 0; i < HT * VT + 2; i++) begin
            cyc();
            if (m_started != 0 && m_h == th && m_v == tv) break;
        end
    endtask

    initial begin
        model_reset();
        bus.r_in = '0; bus.g_in = '0; bus.b_in = '0;
        bus.dither_mode = 2'd0; bus.frame_clear = 1'b0;
        @(negedge clk48);
        chk_idle("reset");
        for (int i = 0; i < 3; i++) cyc();
        rst_n = 1'b1;

        // Round mode with extremes and midpoint mixed into random colour.
        col_mode = 2;
        for (int i = 0; i < 500; i++) cyc();

        // Static Bayer over two frames: pixel (0,0) identical.
        dm_drv = 2'd1;
        col_mode = 1; fix_r = 21;
        px00_q.delete();
        run_to(0, 5);
        run_to(0, 5);
        chk("px00_static_count", 32'(px00_q.size()), 32'd2);
        if (px00_q.size() >= 2) chk("px00_static_same", 32'(px00_q[0] == px00_q[1]), 32'd1);

        // Switch to temporal mid-frame; takes effect only at the next frame.
        dm_drv = 2'd2;
        px00_q.delete();
        run_to(0, 5);
        run_to(0, 5);
        chk("px00_temporal_count", 32'(px00_q.size()), 32'd2);
        if (px00_q.size() >= 2) begin
            chk("px00_odd_frame", 32'(px00_q[0]), 32'd1);
            chk("px00_even_frame", 32'(px00_q[1]), 32'd0);
        end

        // Frame clear mid-frame, then a clear exactly on the wrap.
        col_mode = 0; dm_drv = 2'd3;
        fc_drv = 1'b1; cyc(); fc_drv = 1'b0;
        run_to(0, 0);
        chk("clear_mid_frame", 32'(bus.frame), 32'd0);
        run_to(0, 0);
        chk("clear_then_count", 32'(bus.frame), 32'd1);
        run_to(HT - 1, VT - 1);
        fc_drv = 1'b1; cyc(); fc_drv = 1'b0;
        chk("clear_at_wrap", 32'(bus.frame), 32'd0);
        run_to(0, 3);

        // Asynchronous reset mid-line, then restart from the top of frame.
        run_to(20, 3);
        #2 rst_n = 1'b0;
        #1 chk_idle("async_reset");
        model_reset();
        @(negedge clk48);
        n++;
        for (int i = 0; i < 3; i++) cyc();
        rst_n = 1'b1;
        col_mode = 2;
        for (int i = 0; i < 1300; i++) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
